// File: rtl/twos_to_signmag_serial_pkg.sv
// twos_to_signmag_serial_pkg: shared FSM state encoding and counter width helper
package twos_to_signmag_serial_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
    function automatic int cnt_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bit_counter.sv
// bit_counter: counts processed bits, flags the last one
module bit_counter
    import twos_to_signmag_serial_pkg::*;
#(
    parameter int N = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam int W = cnt_w(N);
    logic [W-1:0] count;
    always_ff @(posedge clk) begin
        if (rst || clear) count <= '0;
        else if (en) count <= count + W'(1);
    end
    assign tc = count == W'(N - 1);
endmodule

// File: rtl/xor_cell.sv
// xor_cell: single-bit XOR
module xor_cell (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

// File: rtl/twos_to_signmag_serial.sv
// twos_to_signmag_serial: bit-serial two's-complement to sign-magnitude converter
module twos_to_signmag_serial
    import twos_to_signmag_serial_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] din,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] abs_out,
    output logic         sign_out
);
    state_t state, next;
    logic [N-1:0] sr, res, nxt_res;
    logic sign, seen, bit_out, tc, load;
    assign load = state == IDLE && start;
    assign busy = state == SHIFT;
    assign done = state == DONE;
    always_ff @(posedge clk) state <= rst ? IDLE : next;
    always_comb begin
        next = IDLE;
        next = state == IDLE  ? (start ? SHIFT : IDLE) :
               state == SHIFT ? (tc ? DONE : SHIFT) : IDLE;
    end
    bit_counter #(.N(N)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clear(load),
        .en   (busy),
        .tc   (tc)
    );
    // Negative operands: pass bits up to the first 1, invert the rest
    xor_cell u_xor (
        .a(sr[0]),
        .b(sign & seen),
        .y(bit_out)
    );
    assign nxt_res = {bit_out, res[N-1:1]};
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            res      <= '0;
            sign     <= 1'b0;
            seen     <= 1'b0;
            abs_out  <= '0;
            sign_out <= 1'b0;
        end else if (load) begin
            sr   <= din;
            res  <= '0;
            sign <= din[N-1];
            seen <= 1'b0;
        end else if (busy) begin
            sr   <= sr >> 1;
            res  <= nxt_res;
            seen <= seen | sr[0];
            if (tc) begin
                abs_out  <= nxt_res;
                sign_out <= sign;
            end
        end
    end
endmodule

// File: tb/tb_twos_to_signmag_serial.sv
// tb_twos_to_signmag_serial: randomized and directed checks against an arithmetic model
module tb_twos_to_signmag_serial;
    localparam int N = 5;
    logic clk = 0, rst = 1, start = 0;
    logic [N-1:0] din = '0;
    logic busy, done, sign_out;
    logic [N-1:0] abs_out;
    int passed = 0, total = 0;
    logic [N-1:0] exp_abs = '0;
    logic exp_sign = 1'b0;

    twos_to_signmag_serial #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din),
        .busy(busy), .done(done), .abs_out(abs_out), .sign_out(sign_out)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] model_abs(input logic [N-1:0] v);
        int s;
        s = v[N-1] ? int'(v) - (1 << N) : int'(v);
        s = s < 0 ? -s : s;
        return s[N-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic eb, input logic ed);
        total++;
        if (busy !== eb || done !== ed || abs_out !== exp_abs || sign_out !== exp_sign)
            $display("FAIL %s got busy=%b done=%b abs=%b sign=%b exp busy=%b done=%b abs=%b sign=%b",
                     name, busy, done, abs_out, sign_out, eb, ed, exp_abs, exp_sign);
        else passed++;
    endtask

    // Converts v; optionally injects a second start at shift sample index mid
    task automatic run_conv(input logic [N-1:0] v, input int mid, input string name);
        start = 1;
        din = v;
        tick();
        start = 0;
        din = N'($urandom);
        for (int i = 0; i < N; i++) begin
            check_out({name, "_shift"}, 1'b1, 1'b0);
            if (i == mid) begin
                start = 1;
                din = 5'b00001;
            end
            tick();
            start = 0;
            din = N'($urandom);
        end
        exp_abs = model_abs(v);
        exp_sign = v[N-1];
        check_out({name, "_done"}, 1'b0, 1'b1);
        tick();
        check_out({name, "_idle"}, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
        check_out("reset", 1'b0, 1'b0);
        start = 0;
        for (int i = 0; i < 3; i++) begin
            din = N'($urandom);
            tick();
            check_out("idle_hold", 1'b0, 1'b0);
        end
    endtask

    task automatic test_directed();
        run_conv(5'b11101, -1, "neg3");
        total++;
        if (abs_out !== 5'b00011) $display("FAIL neg3_abs got=%b exp=00011", abs_out); else passed++;
        run_conv(5'b01011, -1, "pos11");
        run_conv(5'b10000, -1, "most_neg");
        total++;
        if (abs_out !== 5'b10000 || sign_out !== 1'b1)
            $display("FAIL most_neg_abs got=%b/%b exp=10000/1", abs_out, sign_out);
        else passed++;
        run_conv(5'b00000, -1, "zero");
    endtask

    task automatic test_ignore_start();
        run_conv(5'b11111, 1, "mid_start");
        total++;
        if (abs_out !== 5'b00001 || sign_out !== 1'b1)
            $display("FAIL mid_start_result got=%b/%b exp=00001/1", abs_out, sign_out);
        else passed++;
        for (int i = 0; i < N + 2; i++) begin
            tick();
            check_out("mid_start_no_second_done", 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        start = 1;
        din = 5'b11111;
        tick();
        start = 0;
        tick();
        rst = 1;
        tick();
        rst = 0;
        exp_abs = '0;
        exp_sign = 1'b0;
        check_out("reset_mid", 1'b0, 1'b0);
        for (int i = 0; i < N + 3; i++) begin
            tick();
            check_out("reset_mid_no_done", 1'b0, 1'b0);
        end
        run_conv(5'b11101, -1, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) run_conv(N'($urandom), -1, "random");
    endtask

    task automatic test_back_to_back();
        for (int v = 0; v < (1 << N); v++) run_conv(N'(v), -1, "sweep");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
